// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared defines for the store-path UART transmitter
package uart_tx_fifo_pkg;

    localparam logic [31:0] UART_ADDR       = 32'h1000_0000;
    localparam int          DEFAULT_CLK_DIV = 868;
    localparam int          BAUD_W          = 16;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count; writes while full are dropped
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // full is sampled before the edge, so a pop in the same cycle cannot rescue a write
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign full     = (level == (AW + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 serializer with back-to-back framing
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   overflow,
    output logic                   uart_tx
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]        bit_idx, bit_nxt;
    logic [7:0]        shift, shift_nxt;
    logic              tx_nxt;
    logic              pop;
    logic [7:0]        head;
    logic              bit_end;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign bit_end = (baud_cnt == BAUD_W'(CLK_DIV - 1));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            uart_tx  <= tx_nxt;
            overflow <= wr_en & full;
        end
    end

    // uart_tx is registered, so each branch computes the line level for the coming cycle
    always_comb begin
        state_nxt = state;
        baud_nxt  = bit_end ? '0 : baud_cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = uart_tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                tx_nxt   = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        shift_nxt = {1'b0, shift[7:1]};
                        tx_nxt    = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = head;
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
